mem_access_unit: RTL

Sequential load/store initiator that turns one pipeline memory request at a time into accesses on the 64-bit physical-memory port: 8-byte-aligned address, byte write mask, read-enable strobe and read-data return. It sits between the LSU stage and the physical-memory model. It handles alignment, lane shifting, sign/zero extension and misalignment detection, and gives the pipeline a valid/ready request and response handshake.

---
 rtl/mem_access_unit.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// mem_access_unit
// Sequential load/store initiator: accepts one pipeline memory request at a
// time and turns it into accesses on a 64-bit physical-memory port. It
// handles the dword alignment, byte-lane shifting, load sign/zero extension
// and misalignment detection.
//
// Ports:
//   clock, reset          core clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_wen               1 = store, 0 = load
//   req_addr              byte address
//   req_size              0 byte, 1 half, 2 word, 3 dword
//   req_signed            sign-extend load result when 1
//   req_wdata             right-justified store data
//   resp_valid/resp_ready response handshake
//   resp_rdata            extended load data (0 for stores and errors)
//   resp_err              misaligned access
//   mem_raddr/mem_rvalid  dword read address and read strobe
//   mem_rdata             dword read data, valid alongside mem_rvalid
//   mem_waddr/mem_wdata   dword write address and lane-shifted store data
//   mem_wmask             byte-enable mask, 0 = no write
//
// Parameter MEM_LAT (0..15): extra cycles mem_rvalid is held before
// mem_rdata is sampled.
module mem_access_unit #(
  parameter int MEM_LAT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mem_raddr,
  output logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] LAT_C = 4'(MEM_LAT);

  // Byte-enable pattern of an access of the given size before lane shifting.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      2'd3:    size_mask = 8'hFF;
      default: size_mask = 8'h00;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_bits(input logic [1:0] size);
    case (size)
      2'd0:    align_bits = 3'd0;
      2'd1:    align_bits = 3'd1;
      2'd2:    align_bits = 3'd3;
      2'd3:    align_bits = 3'd7;
      default: align_bits = 3'd7;
    endcase
  endfunction

  // Truncate right-justified data to the access size and extend it.
  function automatic logic [63:0] extend_load(input logic [63:0] raw,
                                              input logic [1:0]  size,
                                              input logic        sgn);
    case (size)
      2'd0:    extend_load = {{56{sgn & raw[7]}},  raw[7:0]};
      2'd1:    extend_load = {{48{sgn & raw[15]}}, raw[15:0]};
      2'd2:    extend_load = {{32{sgn & raw[31]}}, raw[31:0]};
      2'd3:    extend_load = raw;
      default: extend_load = raw;
    endcase
  endfunction

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [2:0]  off_r;
  logic [1:0]  size_r;
  logic        wen_r;
  logic        signed_r;

  logic        misalign_s;
  logic [7:0]  lane_mask_s;
  logic [63:0] aligned_s;
  logic [63:0] shift_wdata_s;
  logic [63:0] load_data_s;

  // Request decode and load-data extraction; these only feed registers.
  always_comb begin
    misalign_s    = (req_addr[2:0] & align_bits(req_size)) != 3'd0;
    lane_mask_s   = size_mask(req_size) << req_addr[2:0];
    aligned_s     = {req_addr[63:3], 3'b000};
    shift_wdata_s = req_wdata << {req_addr[2:0], 3'b000};
    load_data_s   = extend_load(mem_rdata >> {off_r, 3'b000}, size_r, signed_r);
  end

  // Control FSM; every output is a register updated on state transitions.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      off_r      <= 3'd0;
      size_r     <= 2'd0;
      wen_r      <= 1'b0;
      signed_r   <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
      mem_raddr  <= 64'd0;
      mem_rvalid <= 1'b0;
      mem_waddr  <= 64'd0;
      mem_wdata  <= 64'd0;
      mem_wmask  <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready) begin
            off_r     <= req_addr[2:0];
            size_r    <= req_size;
            wen_r     <= req_wen;
            signed_r  <= req_signed;
            cnt_r     <= 4'd0;
            req_ready <= 1'b0;
            if (misalign_s) begin
              // Misaligned requests never touch the memory port.
              state_r    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 64'd0;
            end else if (req_wen) begin
              state_r   <= ISSUE;
              mem_waddr <= aligned_s;
              mem_wdata <= shift_wdata_s;
              mem_wmask <= lane_mask_s;
            end else begin
              state_r    <= ISSUE;
              mem_raddr  <= aligned_s;
              mem_rvalid <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (wen_r) begin
            // Store mask is up for exactly one cycle.
            state_r    <= RESP;
            mem_waddr  <= 64'd0;
            mem_wdata  <= 64'd0;
            mem_wmask  <= 8'd0;
            resp_valid <= 1'b1;
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
          end else if (cnt_r == LAT_C) begin
            // Last strobe cycle: mem_rdata is valid now.
            state_r    <= RESP;
            mem_raddr  <= 64'd0;
            mem_rvalid <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= load_data_s;
            resp_err   <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_r    <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          cnt_r      <= 4'd0;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= 64'd0;
          resp_err   <= 1'b0;
          mem_raddr  <= 64'd0;
          mem_rvalid <= 1'b0;
          mem_waddr  <= 64'd0;
          mem_wdata  <= 64'd0;
          mem_wmask  <= 8'd0;
        end
      endcase
    end
  end

endmodule
